// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and bit-timing helper.
// Both uart_tx and uart_rx import this so their encodings never drift apart.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'b000,
    TX_START  = 3'b001,
    TX_DATA   = 3'b010,
    TX_PARITY = 3'b011,
    TX_STOP   = 3'b100
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'b000,
    RX_START  = 3'b001,
    RX_DATA   = 3'b010,
    RX_PARITY = 3'b011,
    RX_STOP   = 3'b100
  } rx_state_t;

  function automatic int countsPerBit(input int baseFreq, input int baudrate);
    return baseFreq / baudrate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..COUNTS_PER_BIT-1 and flags the terminal count.
// A clear restarts the period so a new frame's first bit gets its full width.
module uart_baud_gen #(
  parameter int COUNTS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bitTick
);

  localparam logic [31:0] TERMINAL = 32'(COUNTS_PER_BIT - 1);

  logic [31:0] r_clockCtr;
  logic        w_terminal;

  assign w_terminal = (r_clockCtr == TERMINAL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clockCtr <= '0;
    end else if (i_clear || w_terminal) begin
      r_clockCtr <= '0;
    end else begin
      r_clockCtr <= r_clockCtr + 32'd1;
    end
  end

  // A clear overrides a coincident terminal count so the FSM never sees a stale tick.
  assign o_bitTick = w_terminal && !i_clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as
// start, D0..D7 LSB first, parity, then STOP_BITS stop bits; line idles high.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BASE_FREQ  = 50_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data_in,
  input  logic       i_data_in_valid,
  output logic       o_tx_ready,
  output logic       o_serial_out,
  output logic       o_tx_done
);

  localparam int         COUNTS_PER_BIT = countsPerBit(BASE_FREQ, BAUDRATE);
  localparam logic [2:0] LAST_DATA      = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP      = 3'(STOP_BITS - 1);
  localparam logic       PARITY_INIT    = (PARITY_ODD != 0);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic       r_parity;
  logic [2:0] r_dIdx;
  logic       r_serial;
  logic       r_done;

  tx_state_t  w_nextState;
  logic [7:0] w_nextShift;
  logic       w_nextParity;
  logic [2:0] w_nextDIdx;
  logic       w_nextSerial;
  logic       w_nextDone;
  logic       w_baudClear;
  logic       w_bitTick;
  logic [2:0] w_dIdxInc;

  uart_baud_gen #(
    .COUNTS_PER_BIT(COUNTS_PER_BIT)
  ) u_baudGen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_baudClear),
    .o_bitTick (w_bitTick)
  );

  assign w_dIdxInc = r_dIdx + 3'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= TX_IDLE;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_dIdx   <= '0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_dIdx   <= w_nextDIdx;
      r_serial <= w_nextSerial;
      r_done   <= w_nextDone;
    end
  end

  // The line level for the next bit is decided here and registered, so each
  // transition appears on exactly the edge that ends the previous bit.
  always_comb begin
    w_nextState  = r_state;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_nextDIdx   = r_dIdx;
    w_nextSerial = r_serial;
    w_nextDone   = 1'b0;
    w_baudClear  = 1'b0;

    case (r_state)
      TX_IDLE: begin
        w_nextSerial = 1'b1;
        if (i_data_in_valid) begin
          w_nextState  = TX_START;
          w_nextShift  = i_data_in;
          w_nextParity = (^i_data_in) ^ PARITY_INIT;
          w_nextDIdx   = '0;
          w_nextSerial = 1'b0;
          w_baudClear  = 1'b1;
        end
      end
      TX_START: begin
        if (w_bitTick) begin
          w_nextState  = TX_DATA;
          w_nextDIdx   = '0;
          w_nextSerial = r_shift[0];
        end
      end
      TX_DATA: begin
        if (w_bitTick) begin
          w_nextDIdx = w_dIdxInc;
          if (r_dIdx == LAST_DATA) begin
            w_nextState  = TX_PARITY;
            w_nextSerial = r_parity;
          end else begin
            w_nextSerial = r_shift[w_dIdxInc];
          end
        end
      end
      TX_PARITY: begin
        if (w_bitTick) begin
          w_nextState  = TX_STOP;
          w_nextDIdx   = '0;
          w_nextSerial = 1'b1;
        end
      end
      // d_idx doubles as the stop-bit counter when two stop bits are configured.
      TX_STOP: begin
        w_nextSerial = 1'b1;
        if (w_bitTick) begin
          if (r_dIdx == LAST_STOP) begin
            w_nextState = TX_IDLE;
            w_nextDIdx  = '0;
            w_nextDone  = 1'b1;
          end else begin
            w_nextDIdx = w_dIdxInc;
          end
        end
      end
      default: begin
        w_nextState  = TX_IDLE;
        w_nextSerial = 1'b1;
      end
    endcase
  end

  assign o_tx_ready   = (r_state == TX_IDLE);
  assign o_serial_out = r_serial;
  assign o_tx_done    = r_done;

endmodule
